parking_controller: RTL and testbench

Two-floor car-park access controller. It takes PS/2 scan-code key strobes from a keypad front end and validates 3-digit entry and exit codes. It tracks free spaces per floor and drives four 7-segment digits plus status LEDs. It sits between the keyboard receiver and the board's display/LED pins.

---
 rtl/parking_controller.sv | 161 ++++++++++++++++
 tb/tb_parking_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller.sv
// Two-floor car-park access controller: captures PS/2 digit keys, validates
// 3-digit entry/exit codes, tracks free spaces per floor and drives 7-segment/LED outputs.
module parking_controller #(
    parameter int          CAP1       = 9,
    parameter int          CAP2       = 9,
    parameter logic [11:0] ENTRY_CODE = 12'h113,
    parameter logic [11:0] EXIT_CODE  = 12'h202
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       flr,
    input  logic [7:0] key1_code,
    input  logic       key1_on,
    output logic [6:0] first_rem_BCD,
    output logic [6:0] second_rem_BCD,
    output logic [6:0] tot_rem_BCD_left,
    output logic [6:0] tot_rem_BCD_right,
    output logic       red_power_led,
    output logic       red_wrong_led,
    output logic       green_led
);

    localparam logic [6:0] BLANK  = 7'b1111111;
    localparam logic [3:0] CAP1_L = 4'(CAP1);
    localparam logic [3:0] CAP2_L = 4'(CAP2);

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Returns {valid, digit}; non-digit make codes decode as invalid.
    function automatic logic [4:0] decode_key(input logic [7:0] code);
        logic [4:0] d;
        case (code)
            8'h45:   d = {1'b1, 4'd0};
            8'h16:   d = {1'b1, 4'd1};
            8'h1E:   d = {1'b1, 4'd2};
            8'h26:   d = {1'b1, 4'd3};
            8'h25:   d = {1'b1, 4'd4};
            8'h2E:   d = {1'b1, 4'd5};
            8'h36:   d = {1'b1, 4'd6};
            8'h3D:   d = {1'b1, 4'd7};
            8'h3E:   d = {1'b1, 4'd8};
            8'h46:   d = {1'b1, 4'd9};
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    logic        key_prev;
    logic [1:0]  digit_cnt;
    logic [7:0]  digit_buf;
    logic [3:0]  free1;
    logic [3:0]  free2;
    logic [4:0]  key_dec;
    logic        capture;
    logic [11:0] code;
    logic [4:0]  total;
    logic [4:0]  units;

    assign key_dec = decode_key(key1_code);
    assign capture = key1_on && !key_prev && key_dec[4];
    assign code    = {digit_buf, key_dec[3:0]};
    assign total   = {1'b0, free1} + {1'b0, free2};
    assign units   = (total >= 5'd10) ? total - 5'd10 : total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev          <= 1'b0;
            digit_cnt         <= 2'd0;
            digit_buf         <= 8'd0;
            free1             <= CAP1_L;
            free2             <= CAP2_L;
            green_led         <= 1'b0;
            red_wrong_led     <= 1'b0;
            red_power_led     <= 1'b1;
            first_rem_BCD     <= BLANK;
            second_rem_BCD    <= BLANK;
            tot_rem_BCD_left  <= BLANK;
            tot_rem_BCD_right <= BLANK;
        end else if (!power) begin
            // Reloading key_prev makes a key held across power-up look stale.
            key_prev          <= key1_on;
            digit_cnt         <= 2'd0;
            digit_buf         <= 8'd0;
            free1             <= CAP1_L;
            free2             <= CAP2_L;
            green_led         <= 1'b0;
            red_wrong_led     <= 1'b0;
            red_power_led     <= 1'b1;
            first_rem_BCD     <= BLANK;
            second_rem_BCD    <= BLANK;
            tot_rem_BCD_left  <= BLANK;
            tot_rem_BCD_right <= BLANK;
        end else begin
            key_prev          <= key1_on;
            red_power_led     <= 1'b0;
            first_rem_BCD     <= seg7(free1);
            second_rem_BCD    <= seg7(free2);
            tot_rem_BCD_left  <= seg7((total >= 5'd10) ? 4'd1 : 4'd0);
            tot_rem_BCD_right <= seg7(units[3:0]);
            if (capture) begin
                case (digit_cnt)
                    2'd0: begin
                        digit_buf[7:4] <= key_dec[3:0];
                        digit_cnt      <= 2'd1;
                        green_led      <= 1'b0;
                        red_wrong_led  <= 1'b0;
                    end
                    2'd1: begin
                        digit_buf[3:0] <= key_dec[3:0];
                        digit_cnt      <= 2'd2;
                    end
                    default: begin
                        digit_cnt <= 2'd0;
                        if (code == ENTRY_CODE) begin
                            if (!flr && free1 != 4'd0) begin
                                free1     <= free1 - 4'd1;
                                green_led <= 1'b1;
                            end else if (flr && free2 != 4'd0) begin
                                free2     <= free2 - 4'd1;
                                green_led <= 1'b1;
                            end else begin
                                red_wrong_led <= 1'b1;
                            end
                        end else if (code == EXIT_CODE) begin
                            if (!flr && free1 != CAP1_L) begin
                                free1     <= free1 + 4'd1;
                                green_led <= 1'b1;
                            end else if (flr && free2 != CAP2_L) begin
                                free2     <= free2 + 4'd1;
                                green_led <= 1'b1;
                            end else begin
                                red_wrong_led <= 1'b1;
                            end
                        end else begin
                            red_wrong_led <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parking_controller.sv
// Bench for parking_controller: directed test-plan steps followed by random key
// sequences, all checked against a decimal/queue model of the car park.
`timescale 1ns/1ps
module tb_parking_controller;

    localparam int          CAP1       = 9;
    localparam int          CAP2       = 9;
    localparam logic [11:0] ENTRY_CODE = 12'h113;
    localparam logic [11:0] EXIT_CODE  = 12'h202;
    localparam logic [6:0]  BLANK      = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic       flr;
    logic [7:0] key1_code;
    logic       key1_on;
    logic [6:0] first_rem_BCD, second_rem_BCD, tot_rem_BCD_left, tot_rem_BCD_right;
    logic       red_power_led, red_wrong_led, green_led;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [7:0] key_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Reference model: free counts, pending digits, result lamps, powered flag.
    int m_free1, m_free2;
    int m_q[$];
    bit m_green, m_red, m_on;
    int entry_dec, exit_dec;

    parking_controller #(.CAP1(CAP1), .CAP2(CAP2), .ENTRY_CODE(ENTRY_CODE), .EXIT_CODE(EXIT_CODE)) dut (
        .clk(clk), .rst(rst), .power(power), .flr(flr),
        .key1_code(key1_code), .key1_on(key1_on),
        .first_rem_BCD(first_rem_BCD), .second_rem_BCD(second_rem_BCD),
        .tot_rem_BCD_left(tot_rem_BCD_left), .tot_rem_BCD_right(tot_rem_BCD_right),
        .red_power_led(red_power_led), .red_wrong_led(red_wrong_led), .green_led(green_led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int bcd_to_dec(input logic [11:0] v);
        int x;
        x = int'(v);
        return ((x / 256) % 16) * 100 + ((x / 16) % 16) * 10 + (x % 16);
    endfunction

    function automatic int digit_of(input logic [7:0] c);
        for (int i = 0; i < 10; i++)
            if (key_tab[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [6:0] exp_seg(input int v);
        return m_on ? seg_tab[v] : BLANK;
    endfunction

    task automatic model_clear(input bit on);
        m_free1 = CAP1;
        m_free2 = CAP2;
        m_q.delete();
        m_green = 1'b0;
        m_red   = 1'b0;
        m_on    = on;
    endtask

    task automatic model_press(input logic [7:0] c, input logic f);
        int d, v;
        d = digit_of(c);
        if (d < 0) return;
        if (m_q.size() == 0) begin
            m_green = 1'b0;
            m_red   = 1'b0;
        end
        m_q.push_back(d);
        if (m_q.size() == 3) begin
            v = m_q[0] * 100 + m_q[1] * 10 + m_q[2];
            m_q.delete();
            if (v == entry_dec) begin
                if (!f && m_free1 > 0) begin m_free1--; m_green = 1'b1; end
                else if (f && m_free2 > 0) begin m_free2--; m_green = 1'b1; end
                else m_red = 1'b1;
            end else if (v == exit_dec) begin
                if (!f && m_free1 < CAP1) begin m_free1++; m_green = 1'b1; end
                else if (f && m_free2 < CAP2) begin m_free2++; m_green = 1'b1; end
                else m_red = 1'b1;
            end else begin
                m_red = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int tot;
        tot = m_free1 + m_free2;
        check({tag, ".first"},     first_rem_BCD,      exp_seg(m_free1));
        check({tag, ".second"},    second_rem_BCD,     exp_seg(m_free2));
        check({tag, ".tot_left"},  tot_rem_BCD_left,   exp_seg(tot / 10));
        check({tag, ".tot_right"}, tot_rem_BCD_right,  exp_seg(tot % 10));
        check({tag, ".green"},     {6'd0, green_led},     {6'd0, m_green});
        check({tag, ".red_wrong"}, {6'd0, red_wrong_led}, {6'd0, m_red});
        check({tag, ".red_power"}, {6'd0, red_power_led}, {6'd0, !m_on});
    endtask

    // Inputs change on the falling edge; the key is released with a two-cycle gap.
    task automatic press(input logic [7:0] c, input int hold);
        key1_code = c;
        key1_on   = 1'b1;
        repeat (hold) @(negedge clk);
        key1_on   = 1'b0;
        repeat (2) @(negedge clk);
        model_press(c, flr);
    endtask

    task automatic press_code(input logic [11:0] c, input int hold);
        int x;
        x = int'(c);
        press(key_tab[(x / 256) % 16], hold);
        press(key_tab[(x / 16) % 16], hold);
        press(key_tab[x % 16], hold);
    endtask

    initial begin
        entry_dec = bcd_to_dec(ENTRY_CODE);
        exit_dec  = bcd_to_dec(EXIT_CODE);
        rst = 1'b1; power = 1'b0; flr = 1'b0; key1_code = 8'h00; key1_on = 1'b0;
        model_clear(1'b0);
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("off_after_reset");
        power = 1'b1;
        m_on  = 1'b1;
        @(negedge clk);
        check_all("power_up");

        // Entry on floor 1 with long key holds.
        press(8'h16, 10); press(8'h16, 10); press(8'h26, 10);
        check_all("entry_f1");

        // Exit on floor 1; lamps clear on the first digit.
        press(8'h1E, 10);
        check_all("exit_first_digit");
        press(8'h45, 10); press(8'h1E, 10);
        check_all("exit_f1");
        press(8'h26, 3); press(8'h26, 3); press(8'h16, 3);
        check_all("wrong_code");
        press(8'h45, 3);
        check_all("lone_digit");
        press(8'h16, 3); press(8'h16, 3);
        check_all("finish_partial");

        // Floor 2: exit at capacity, fill it, then one entry too many.
        flr = 1'b1;
        press_code(EXIT_CODE, 2);
        check_all("exit_at_cap");
        for (int i = 0; i < 9; i++) press_code(ENTRY_CODE, 2);
        check_all("f2_full");
        press_code(ENTRY_CODE, 2);
        check_all("f2_overfull");
        flr = 1'b0;

        // Power drop mid-code discards the partial code and refills counts.
        press(8'h1E, 2); press(8'h45, 2);
        power = 1'b0;
        model_clear(1'b0);
        @(negedge clk);
        check_all("power_off");
        power = 1'b1;
        m_on  = 1'b1;
        @(negedge clk);
        press(8'h26, 2);
        check_all("restart_one_digit");
        press(8'h16, 2); press(8'h16, 2);
        check_all("restart_complete");

        // A key held across power-up must not be captured.
        power = 1'b0;
        key1_code = 8'h16;
        key1_on = 1'b1;
        model_clear(1'b0);
        @(negedge clk);
        power = 1'b1;
        m_on  = 1'b1;
        repeat (3) @(negedge clk);
        key1_on = 1'b0;
        @(negedge clk);
        press_code(ENTRY_CODE, 2);
        check_all("held_at_powerup");

        // Break codes between digits do not advance the count.
        press(8'h16, 2); press(8'hF0, 2); press(8'h16, 2); press(8'hE0, 2); press(8'h26, 2);
        check_all("ignored_codes");

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_clear(1'b0);
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst  = 1'b0;
        m_on = 1'b1;
        @(negedge clk);
        check_all("after_reset");

        // Random mix of valid codes, random digits and non-digit keys.
        for (int n = 0; n < 60; n++) begin
            flr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1: press_code(ENTRY_CODE, $urandom_range(1, 4));
                2:    press_code(EXIT_CODE, $urandom_range(1, 4));
                3:    press(key_tab[$urandom_range(0, 9)], $urandom_range(1, 4));
                default: press(($urandom_range(0, 1) == 0) ? 8'hF0 : 8'(($urandom_range(0, 255))),
                               $urandom_range(1, 4));
            endcase
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
